screen_fade_mux: RTL and testbench
==================================

// Module: screen_fade_mux
// PURPOSE
//  Parametrised successor of the screen selector/control pair. It decodes PS/2 make-codes
//  into next/prev/home requests and selects one of N_SCREENS renderer RGB streams.
//  Screen changes are frame-synchronous, with a fade-out/fade-in of FADE_FRAMES frames.
//  It sits between the renderers (all fed from vga_timing) and the board VGA pins.
// PARAMETERS
//  N_SCREENS    4      number of renderer inputs, >=2
//  SEL_W        $clog2(N_SCREENS)  screen index width (derived)
//  RGB_W        12     pixel width, 3 equal channels (RGB_W%3==0)
//  FADE_FRAMES  16     frames per fade half; power of 2, >=1; LVL_W=$clog2(FADE_FRAMES)+1
//  HOME_SCREEN  0      screen index after reset / on KEY_HOME
//  KEY_NEXT     8'h74  make-code: next screen (right arrow)
//  KEY_PREV     8'h6B  make-code: previous screen (left arrow)
//  KEY_HOME     8'h76  make-code: go to HOME_SCREEN (Esc)
// PORTS
//  clk        in   1                  pixel clock
//  rst        in   1                  asynchronous reset, active-low
//  keycode    in   16                 PS/2 {prev byte, last byte}, level, held until next key
//  vsync_in   in   1                  timing vsync
//  hsync_in   in   1                  timing hsync
//  vblnk_in   in   1                  timing vertical blank
//  hblnk_in   in   1                  timing horizontal blank
//  rgb_in     in   N_SCREENS*RGB_W    screen k pixel at bits [k*RGB_W +: RGB_W]
//  vsync_out  out  1                  vsync_in delayed 2 clk
//  hsync_out  out  1                  hsync_in delayed 2 clk
//  rgb_out    out  RGB_W              selected, faded, blanked pixel
//  screen     out  SEL_W              currently displayed screen index
//  busy       out  1                  high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): vsync_out=hsync_out=0, rgb_out=0, screen=HOME_SCREEN, busy=0,
//   state=IDLE, lvl=FADE_FRAMES, key_q=keycode-register 16'h0.
//  Key event: a 1-clk strobe when keycode!=key_q and keycode[15:8]!=8'hF0; code=keycode[7:0].
//   key_q<=keycode every clk. Break codes and unlisted codes generate no request.
//  Target: NEXT -> (screen+1) wraps N_SCREENS-1 -> 0; PREV -> (screen-1) wraps 0 -> N_SCREENS-1;
//   HOME -> HOME_SCREEN. When target==screen, no request (state unchanged).
//  Frame tick: rising edge of vsync_in (registered compare), 1-clk strobe.
//  FSM:
//   IDLE     : request -> tgt<=target, PENDING.
//   PENDING  : a new request overwrites tgt (computed from current screen); on tick -> FADE_OUT.
//   FADE_OUT : each tick lvl<=lvl-1; on the tick that makes lvl 0 -> SWITCH.
//   SWITCH   : screen<=tgt (one clk), -> FADE_IN.
//   FADE_IN  : each tick lvl<=lvl+1; on the tick that makes lvl FADE_FRAMES -> IDLE.
//   Key events in FADE_OUT/SWITCH/FADE_IN are dropped. The screen output changes only in SWITCH.
//  Pixel pipe, 2 clk latency:
//   S1 registers rgb_in[screen] and hblnk|vblnk.
//   S2: each channel c_out = (c*lvl) >> log2(FADE_FRAMES), computed at full width
//    (CH_W+LVL_W) and then truncated to CH_W. rgb_out=0 when the S1 blank flag=1.
//   At lvl=FADE_FRAMES the output equals the input exactly. Syncs are delayed 2 clk to match.
//  A full transition takes 2*FADE_FRAMES ticks (+1 clk), after waiting up to 1 frame in PENDING.
//  A reset mid-fade returns to IDLE/HOME at full brightness immediately. There is no partial state.
// TESTING
//  1 Reset, rgb_in screen0=12'hABC, others 0, no keys -> after 2 clk rgb_out=12'hABC outside blank, 0 inside; screen=0.
//  2 keycode 16'h0074 then 16'hF074 -> one request. PENDING until vsync rise, then lvl 16->0 over 16 frames;
//    screen=1 at SWITCH; 16 frames later lvl=16, busy=0.
//  3 Wrap: from screen=3, key 8'h74 -> screen 0. From screen 0, key 8'h6B -> screen 3.
//    KEY_HOME on screen 0 -> busy stays 0.
//  4 Fade math: screen pixel 12'hFFF, lvl=8 (FADE_FRAMES=16) -> rgb_out=12'h777. lvl=0 -> 12'h000.
//  5 Keys during FADE_OUT are ignored. Two keys (NEXT, NEXT) in PENDING from screen 0 -> tgt=1, not 2.
//  6 rst=0 asserted mid-FADE_OUT (lvl=5) -> same clk edge: screen=HOME, busy=0, rgb_out=0;
//    after release, full brightness.

Source files
------------

// File: rtl/screen_fade_mux.sv
// Screen selector with PS/2 next/prev/home keys and a frame-synchronous fade-out/fade-in.
// Pixel path: renderer mux -> brightness scale -> blanking, 2 clk latency, syncs delayed to match.
module screen_fade_mux #(
    parameter int         N_SCREENS   = 4,
    parameter int         SEL_W       = $clog2(N_SCREENS),
    parameter int         RGB_W       = 12,
    parameter int         FADE_FRAMES = 16,
    parameter int         HOME_SCREEN = 0,
    parameter logic [7:0] KEY_NEXT    = 8'h74,
    parameter logic [7:0] KEY_PREV    = 8'h6B,
    parameter logic [7:0] KEY_HOME    = 8'h76
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                keycode,
    input  logic                       vsync_in,
    input  logic                       hsync_in,
    input  logic                       vblnk_in,
    input  logic                       hblnk_in,
    input  logic [N_SCREENS*RGB_W-1:0] rgb_in,
    output logic                       vsync_out,
    output logic                       hsync_out,
    output logic [RGB_W-1:0]           rgb_out,
    output logic [SEL_W-1:0]           screen,
    output logic                       busy
);

    localparam int LVL_W  = $clog2(FADE_FRAMES) + 1;
    localparam int CH_W   = RGB_W / 3;
    localparam int SHIFT  = LVL_W - 1;
    localparam int PROD_W = CH_W + LVL_W;

    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N_SCREENS - 1);
    localparam logic [SEL_W-1:0] HOME_IDX   = SEL_W'(HOME_SCREEN);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FADE_FRAMES);
    localparam logic [LVL_W-1:0] LVL_ALMOST = LVL_W'(FADE_FRAMES - 1);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    state_t           state;
    logic [LVL_W-1:0] lvl;
    logic [SEL_W-1:0] tgt;
    logic [15:0]      key_q;
    logic             vsync_q;

    logic             key_evt;
    logic             key_known;
    logic [SEL_W-1:0] target;
    logic             req;
    logic             tick;

    // NOTE: combinational decode uses blocking '=' with a default for every output first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        key_evt   = (keycode != key_q) && (keycode[15:8] != 8'hF0);
        key_known = 1'b0;
        target    = screen;
        case (keycode[7:0])
            KEY_NEXT: begin
                key_known = 1'b1;
                target    = (screen == LAST_IDX) ? '0 : screen + 1'b1;
            end
            KEY_PREV: begin
                key_known = 1'b1;
                target    = (screen == '0) ? LAST_IDX : screen - 1'b1;
            end
            KEY_HOME: begin
                key_known = 1'b1;
                target    = HOME_IDX;
            end
            default: ;
        endcase
        req  = key_evt && key_known && (target != screen);
        tick = vsync_in && !vsync_q;
    end

    // NOTE: all state registers use non-blocking '<=' so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lvl     <= LVL_FULL;
            screen  <= HOME_IDX;
            tgt     <= HOME_IDX;
            busy    <= 1'b0;
            key_q   <= 16'h0;
            vsync_q <= 1'b0;
        end else begin
            key_q   <= keycode;
            vsync_q <= vsync_in;
            case (state)
                IDLE: begin
                    if (req) begin
                        tgt   <= target;
                        state <= PENDING;
                        busy  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (req)  tgt   <= target;
                    if (tick) state <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (tick) begin
                        lvl <= lvl - 1'b1;
                        if (lvl == LVL_ONE) state <= SWITCH;
                    end
                end
                SWITCH: begin
                    screen <= tgt;
                    state  <= FADE_IN;
                end
                FADE_IN: begin
                    if (tick) begin
                        lvl <= lvl + 1'b1;
                        if (lvl == LVL_ALMOST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [RGB_W-1:0] pix_s1;
    logic             blank_s1;
    logic [1:0]       vsync_d;
    logic [1:0]       hsync_d;
    logic [RGB_W-1:0] faded;

    // Scale at full product width, then truncate; lvl == FADE_FRAMES is an exact pass-through.
    always_comb begin
        faded = '0;
        for (int c = 0; c < 3; c++) begin
            faded[c*CH_W +: CH_W] =
                CH_W'((PROD_W'(pix_s1[c*CH_W +: CH_W]) * PROD_W'(lvl)) >> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_s1   <= '0;
            blank_s1 <= 1'b0;
            vsync_d  <= 2'b00;
            hsync_d  <= 2'b00;
            rgb_out  <= '0;
        end else begin
            pix_s1   <= rgb_in[screen*RGB_W +: RGB_W];
            blank_s1 <= hblnk_in | vblnk_in;
            vsync_d  <= {vsync_d[0], vsync_in};
            hsync_d  <= {hsync_d[0], hsync_in};
            rgb_out  <= blank_s1 ? '0 : faded;
        end
    end

    assign vsync_out = vsync_d[1];
    assign hsync_out = hsync_d[1];

endmodule

// File: tb/tb_screen_fade_mux.sv
// Directed bench for screen_fade_mux: pipeline, key decode, wrap, fade levels and mid-fade reset.
module tb_screen_fade_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic [47:0] rgb_in;
    logic        vsync_out, hsync_out;
    logic [11:0] rgb_out;
    logic [1:0]  screen;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen_fade_mux dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .vsync_in  (vsync_in),
        .hsync_in  (hsync_in),
        .vblnk_in  (vblnk_in),
        .hblnk_in  (hblnk_in),
        .rgb_in    (rgb_in),
        .vsync_out (vsync_out),
        .hsync_out (hsync_out),
        .rgb_out   (rgb_out),
        .screen    (screen),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vsync_in = 1'b1;
            step(2);
            vsync_in = 1'b0;
            step(2);
        end
    endtask

    task automatic press(input logic [7:0] code);
        keycode = {8'h00, code};
        step(1);
        keycode = {8'hF0, code};
        step(1);
    endtask

    task automatic transition(input logic [7:0] code);
        press(code);
        frames(33);
    endtask

    initial begin
        rst      = 1'b0;
        keycode  = 16'h0000;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
        rgb_in   = 48'h000_000_000_ABC;
        #12;
        check("reset_rgb",    32'(rgb_out), 32'h0);
        check("reset_screen", 32'(screen),  32'h0);
        check("reset_busy",   32'(busy),    32'h0);
        check("reset_vsync",  32'(vsync_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Pipeline latency and blanking
        step(2);
        check("pipe_pass", 32'(rgb_out), 32'hABC);
        hblnk_in = 1'b1;
        step(1);
        check("hblnk_lat1", 32'(rgb_out), 32'hABC);
        step(1);
        check("hblnk_zero", 32'(rgb_out), 32'h0);
        hblnk_in = 1'b0;
        vblnk_in = 1'b1;
        step(2);
        check("vblnk_zero", 32'(rgb_out), 32'h0);
        vblnk_in = 1'b0;
        step(2);
        check("blank_clear", 32'(rgb_out), 32'hABC);

        vsync_in = 1'b1;
        hsync_in = 1'b1;
        step(1);
        check("vsync_d1", 32'(vsync_out), 32'h0);
        step(1);
        check("vsync_d2", 32'(vsync_out), 32'h1);
        check("hsync_d2", 32'(hsync_out), 32'h1);
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        step(2);
        check("idle_tick_busy", 32'(busy), 32'h0);

        // Full transition 0 -> 1 with fade levels observed through a white pixel
        rgb_in  = 48'h123_444_888_FFF;
        keycode = 16'hF074;
        step(2);
        check("break_no_req", 32'(busy), 32'h0);
        keycode = 16'h0074;
        step(1);
        check("req_busy",   32'(busy),   32'h1);
        check("req_screen", 32'(screen), 32'h0);
        keycode = 16'hF074;
        step(3);
        check("pending_full", 32'(rgb_out), 32'hFFF);
        frames(1);
        check("fade_start", 32'(rgb_out), 32'hFFF);
        frames(8);
        check("lvl8", 32'(rgb_out), 32'h777);
        press(8'h6B);
        check("key_in_fade_busy", 32'(busy), 32'h1);
        frames(7);
        check("lvl1_screen", 32'(screen), 32'h0);
        frames(1);
        check("switch_screen", 32'(screen),  32'h1);
        check("lvl0_black",    32'(rgb_out), 32'h0);
        frames(15);
        check("lvl15_busy", 32'(busy),    32'h1);
        check("lvl15_rgb",  32'(rgb_out), 32'h777);
        frames(1);
        check("done_busy",   32'(busy),    32'h0);
        check("done_rgb",    32'(rgb_out), 32'h888);
        check("done_screen", 32'(screen),  32'h1);

        // Wrap in both directions
        transition(8'h74);
        check("s2", 32'(screen), 32'h2);
        check("s2_rgb", 32'(rgb_out), 32'h444);
        transition(8'h74);
        check("s3", 32'(screen), 32'h3);
        check("s3_rgb", 32'(rgb_out), 32'h123);
        transition(8'h74);
        check("wrap_next", 32'(screen), 32'h0);
        transition(8'h6B);
        check("wrap_prev", 32'(screen), 32'h3);
        transition(8'h76);
        check("home", 32'(screen), 32'h0);
        press(8'h76);
        step(2);
        check("home_noop_busy", 32'(busy), 32'h0);

        // Two NEXT requests while pending resolve against the current screen
        press(8'h74);
        press(8'h74);
        frames(33);
        check("double_next", 32'(screen), 32'h1);
        check("double_busy", 32'(busy),   32'h0);

        // Reset in the middle of a fade-out from screen 1
        press(8'h74);
        frames(12);
        check("lvl5_rgb",  32'(rgb_out), 32'h222);
        check("lvl5_busy", 32'(busy),    32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_screen", 32'(screen),  32'h0);
        check("mid_rst_busy",   32'(busy),    32'h0);
        check("mid_rst_rgb",    32'(rgb_out), 32'h0);
        step(2);
        rst = 1'b1;
        step(2);
        check("post_rst_rgb",    32'(rgb_out), 32'hFFF);
        check("post_rst_screen", 32'(screen),  32'h0);
        frames(1);
        check("post_rst_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
